// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared constants for the VGA timing generator family.
//   - Default 640x480@60 timing fields (pixels for H, lines for V).
//   - Derived totals and active-area start positions for the defaults.
//   - Sync polarity encoding and a helper that turns "inside the sync
//     region" into the pin level for a given polarity.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    // Pixel-rate divider and counter width defaults (100 MHz -> 25 MHz).
    localparam int DEF_DIV      = 4;
    localparam int DEF_CW       = 10;

    // Horizontal fields in pixels, in beam order.
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;

    // Vertical fields in lines, in beam order.
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;

    // Derived totals and the first active count on each axis.
    localparam int DEF_H_TOTAL     = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT;
    localparam int DEF_V_TOTAL     = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACTIVE + DEF_V_FRONT;
    localparam int DEF_H_ACT_START = DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_ACT_START = DEF_V_SYNC + DEF_V_BACK;

    // Polarity encoding: the value is the pin level while in the sync region.
    localparam logic POL_ACTIVE_LOW  = 1'b0;
    localparam logic POL_ACTIVE_HIGH = 1'b1;

    // Pin level for a sync output given its polarity and whether the beam
    // is currently inside the sync region.
    function automatic logic syncLevel(input logic pol, input logic inSync);
        return inSync ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// ---------------------------------------------------------------------------
// vga_axis_timer
//
// One beam axis (horizontal or vertical). Holds a wrap counter that runs
// 0..TOTAL-1 and steps when advance_i is high, and decodes the sync,
// active and coordinate values for the count it will hold after this edge,
// so the parent can register them in lockstep with the counter.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   advance_i      step the counter on this edge
//   count_o        current (registered) count
//   carry_o        advance_i while at TOTAL-1, i.e. this edge wraps to 0
//   syncNext_o     sync pin level for the next count
//   activeNext_o   next count lies inside the active region
//   coordNext_o    next count relative to the active start, 0 outside
// ---------------------------------------------------------------------------
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int   CW     = DEF_CW,
    parameter int   SYNC   = DEF_H_SYNC,
    parameter int   BACK   = DEF_H_BACK,
    parameter int   ACTIVE = DEF_H_ACTIVE,
    parameter int   FRONT  = DEF_H_FRONT,
    parameter logic POL    = POL_ACTIVE_LOW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          advance_i,
    output logic [CW-1:0] count_o,
    output logic          carry_o,
    output logic          syncNext_o,
    output logic          activeNext_o,
    output logic [CW-1:0] coordNext_o
);

    localparam int TOTAL = SYNC + BACK + ACTIVE + FRONT;

    // Region bounds are held one bit wider than the counter so that a
    // bound equal to 2^CW (TOTAL filling the counter exactly) still compares
    // correctly.
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW:0]   SYNC_END   = (CW+1)'(SYNC);
    localparam logic [CW:0]   ACT_BEGIN  = (CW+1)'(SYNC + BACK);
    localparam logic [CW:0]   ACT_END    = (CW+1)'(SYNC + BACK + ACTIVE);
    localparam logic [CW-1:0] ACT_OFFSET = CW'(SYNC + BACK);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW:0]   countNextWide;
    logic          atLast;

    // Next-count selection and the decodes of that next count. Decoding the
    // next value rather than the current one lets the parent's output
    // registers change on the same edge as the counter.
    always_comb begin
        atLast  = (count_q == LAST);
        carry_o = advance_i && atLast;
        count_d = count_q;
        if (advance_i) begin
            count_d = atLast ? '0 : count_q + 1'b1;
        end
        countNextWide = {1'b0, count_d};
        syncNext_o    = syncLevel(POL, countNextWide < SYNC_END);
        activeNext_o  = (countNextWide >= ACT_BEGIN) && (countNextWide < ACT_END);
        coordNext_o   = activeNext_o ? (count_d - ACT_OFFSET) : '0;
    end

    // Beam position register for this axis.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA timing generator running entirely in the clk domain.
// A clock-enable divider produces one pixel step every DIV clocks; two
// vga_axis_timer instances track the horizontal and vertical beam position
// and their decodes are registered here so every output moves on the same
// edge as hCount/vCount.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   enable                 low freezes divider, counters and levels
//   hSync, vSync           sync pins, active level set by H_POL / V_POL
//   bright                 beam inside the active area
//   hCount, vCount         raw beam position
//   x, y                   active-area coordinates, 0 outside it
//   pix_tick               one-clk pulse when new counter values appear
//   line_start             one-clk pulse when hCount becomes 0
//   frame_start            one-clk pulse when (hCount, vCount) becomes (0, 0)
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   DIV      = DEF_DIV,
    parameter int   CW       = DEF_CW,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BACK   = DEF_H_BACK,
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FRONT  = DEF_H_FRONT,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BACK   = DEF_V_BACK,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FRONT  = DEF_V_FRONT,
    parameter logic H_POL    = POL_ACTIVE_LOW,
    parameter logic V_POL    = POL_ACTIVE_LOW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          hSync,
    output logic          vSync,
    output logic          bright,
    output logic [CW-1:0] hCount,
    output logic [CW-1:0] vCount,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    // Divider width; a single bit is kept even when DIV is 1 so the
    // register always exists.
    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    // Reject parameter sets that cannot work before anything is built.
    if (DIV < 1) begin : gDivCheck
        $error("vga_timing_gen: DIV must be at least 1");
    end
    if (H_TOTAL > (1 << CW)) begin : gHTotalCheck
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (1 << CW)) begin : gVTotalCheck
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          pe;

    logic          hCarry;
    logic          hSyncNext;
    logic          hActiveNext;
    logic [CW-1:0] hCoordNext;
    logic          vCarry;
    logic          vSyncNext;
    logic          vActiveNext;
    logic [CW-1:0] vCoordNext;
    logic          brightNext;

    logic          hSync_q;
    logic          vSync_q;
    logic          bright_q;
    logic [CW-1:0] x_q;
    logic [CW-1:0] y_q;
    logic          pixTick_q;
    logic          lineStart_q;
    logic          frameStart_q;

    // Pixel-rate divider: counts 0..DIV-1 while enabled, and the pixel
    // enable fires on the last count. With DIV=1 the count stays at 0 and
    // the pixel enable simply follows enable.
    always_comb begin
        pe    = enable && (div_q == DIV_LAST);
        div_d = div_q;
        if (enable) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Horizontal axis steps on every pixel enable.
    vga_axis_timer #(
        .CW     (CW),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .POL    (H_POL)
    ) uHAxis (
        .clk          (clk),
        .reset        (reset),
        .advance_i    (pe),
        .count_o      (hCount),
        .carry_o      (hCarry),
        .syncNext_o   (hSyncNext),
        .activeNext_o (hActiveNext),
        .coordNext_o  (hCoordNext)
    );

    // Vertical axis steps only when the horizontal axis wraps; its carry
    // therefore already implies the horizontal wrap on the same edge.
    vga_axis_timer #(
        .CW     (CW),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .POL    (V_POL)
    ) uVAxis (
        .clk          (clk),
        .reset        (reset),
        .advance_i    (hCarry),
        .count_o      (vCount),
        .carry_o      (vCarry),
        .syncNext_o   (vSyncNext),
        .activeNext_o (vActiveNext),
        .coordNext_o  (vCoordNext)
    );

    assign brightNext = hActiveNext && vActiveNext;

    // Output registers. Levels follow the next-count decodes so they line
    // up with the counters; pulses are only ever raised by a pixel enable,
    // so they are 0 whenever enable is low. Coordinates are forced to 0
    // unless both axes are active.
    always_ff @(posedge clk) begin
        if (reset) begin
            hSync_q      <= H_POL;
            vSync_q      <= V_POL;
            bright_q     <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            pixTick_q    <= 1'b0;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            hSync_q      <= hSyncNext;
            vSync_q      <= vSyncNext;
            bright_q     <= brightNext;
            x_q          <= brightNext ? hCoordNext : '0;
            y_q          <= brightNext ? vCoordNext : '0;
            pixTick_q    <= pe;
            lineStart_q  <= hCarry;
            frameStart_q <= hCarry && vCarry;
        end
    end

    assign hSync       = hSync_q;
    assign vSync       = vSync_q;
    assign bright      = bright_q;
    assign x           = x_q;
    assign y           = y_q;
    assign pix_tick    = pixTick_q;
    assign line_start  = lineStart_q;
    assign frame_start = frameStart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen. Instance A uses the default 640x480
// timing with DIV=4; instance B uses DIV=1, active-high syncs, CW=4 and a
// 16x6 raster so a whole frame can be scanned in a few clocks.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters.
    logic       rstA, enA;
    logic       hSyncA, vSyncA, brightA, tickA, lineA, frameA;
    logic [9:0] hCountA, vCountA, xA, yA;

    // Instance B: small raster, DIV=1, active-high syncs, counter exactly full.
    logic       rstB, enB;
    logic       hSyncB, vSyncB, brightB, tickB, lineB, frameB;
    logic [3:0] hCountB, vCountB, xB, yB;

    int total = 0;
    int bad   = 0;

    vga_timing_gen uDutA (
        .clk         (clk),
        .reset       (rstA),
        .enable      (enA),
        .hSync       (hSyncA),
        .vSync       (vSyncA),
        .bright      (brightA),
        .hCount      (hCountA),
        .vCount      (vCountA),
        .x           (xA),
        .y           (yA),
        .pix_tick    (tickA),
        .line_start  (lineA),
        .frame_start (frameA)
    );

    vga_timing_gen #(
        .DIV      (1),
        .CW       (4),
        .H_SYNC   (8),
        .H_BACK   (2),
        .H_ACTIVE (4),
        .H_FRONT  (2),
        .V_SYNC   (1),
        .V_BACK   (1),
        .V_ACTIVE (3),
        .V_FRONT  (1),
        .H_POL    (1'b1),
        .V_POL    (1'b1)
    ) uDutB (
        .clk         (clk),
        .reset       (rstB),
        .enable      (enB),
        .hSync       (hSyncB),
        .vSync       (vSyncB),
        .bright      (brightB),
        .hCount      (hCountB),
        .vCount      (vCountB),
        .x           (xB),
        .y           (yB),
        .pix_tick    (tickB),
        .line_start  (lineB),
        .frame_start (frameB)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed != expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive both instances' control inputs.
    task automatic applyStimulus(input logic rA, input logic eA, input logic rB, input logic eB);
        rstA = rA;
        enA  = eA;
        rstB = rB;
        enB  = eB;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Run instance A until it shows (h, v), within a bounded number of clocks.
    task automatic waitA(input int h, input int v, input int budget);
        int found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            if (hCountA == h && vCountA == v) begin
                found = 1;
                break;
            end
            stepClock();
        end
        checkOutput($sformatf("A reach (%0d,%0d)", h, v), found, 1);
    endtask

    initial begin
        int holdErr;
        int found;
        int brightCnt, vSyncCnt, tickCnt, lineCnt, frameCnt, hSyncErr;
        int firstH, firstV, firstX, firstY;
        int lastH, lastV, lastX, lastY, maxX;

        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) stepClock();

        // Reset values on both instances.
        checkOutput("A rst hCount", hCountA, 0);
        checkOutput("A rst vCount", vCountA, 0);
        checkOutput("A rst x", xA, 0);
        checkOutput("A rst y", yA, 0);
        checkOutput("A rst bright", brightA, 0);
        checkOutput("A rst hSync", hSyncA, 0);
        checkOutput("A rst vSync", vSyncA, 0);
        checkOutput("A rst pix_tick", tickA, 0);
        checkOutput("A rst line_start", lineA, 0);
        checkOutput("A rst frame_start", frameA, 0);
        checkOutput("B rst hSync", hSyncB, 1);
        checkOutput("B rst vSync", vSyncB, 1);

        // Reset release: hCount reaches 1 on the 4th edge, tick every 4 clks.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        for (int e = 1; e <= 8; e++) begin
            stepClock();
            checkOutput($sformatf("A edge%0d hCount", e), hCountA, e / 4);
            checkOutput($sformatf("A edge%0d pix_tick", e), tickA, (e % 4 == 0) ? 1 : 0);
        end

        // Horizontal sync ends exactly at hCount = 96.
        waitA(95, 0, 2000);
        checkOutput("A hSync at 95", hSyncA, 0);
        repeat (4) stepClock();
        checkOutput("A hCount after 95", hCountA, 96);
        checkOutput("A hSync at 96", hSyncA, 1);

        // Line 0 is vertical sync, so no active area even in the H active span.
        waitA(144, 0, 2000);
        checkOutput("A bright at (144,0)", brightA, 0);
        checkOutput("A x at (144,0)", xA, 0);

        // Enable dropped for 37 clks two clocks into a pixel period.
        waitA(300, 0, 2000);
        repeat (2) stepClock();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        holdErr = 0;
        for (int i = 0; i < 37; i++) begin
            stepClock();
            if (hCountA != 300 || vCountA != 0 || tickA || lineA || frameA || !hSyncA || brightA)
                holdErr++;
        end
        checkOutput("A hold violations", holdErr, 0);
        checkOutput("A hCount held", hCountA, 300);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        stepClock();
        checkOutput("A resume edge1 hCount", hCountA, 300);
        checkOutput("A resume edge1 pix_tick", tickA, 0);
        stepClock();
        checkOutput("A resume edge2 hCount", hCountA, 301);
        checkOutput("A resume edge2 pix_tick", tickA, 1);

        // Line wrap without frame wrap.
        waitA(799, 0, 3000);
        checkOutput("A line_start before wrap", lineA, 0);
        repeat (4) stepClock();
        checkOutput("A wrap hCount", hCountA, 0);
        checkOutput("A wrap vCount", vCountA, 1);
        checkOutput("A wrap line_start", lineA, 1);
        checkOutput("A wrap frame_start", frameA, 0);
        stepClock();
        checkOutput("A line_start one clk", lineA, 0);

        // Reset mid-line takes priority over enable.
        waitA(500, 1, 3000);
        checkOutput("A hSync before reset", hSyncA, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        stepClock();
        checkOutput("A midrst hCount", hCountA, 0);
        checkOutput("A midrst vCount", vCountA, 0);
        checkOutput("A midrst hSync", hSyncA, 0);
        checkOutput("A midrst vSync", vSyncA, 0);
        checkOutput("A midrst bright", brightA, 0);
        checkOutput("A midrst pix_tick", tickA, 0);

        // Instance B: tick every clock from the first edge after release.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
        stepClock();
        checkOutput("B edge1 hCount", hCountB, 1);
        checkOutput("B edge1 pix_tick", tickB, 1);

        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (frameB) begin
                found = 1;
                break;
            end
            stepClock();
        end
        checkOutput("B frame_start reached", found, 1);
        checkOutput("B wrap hCount", hCountB, 0);
        checkOutput("B wrap vCount", vCountB, 0);
        checkOutput("B wrap line_start", lineB, 1);

        // Scan one full 16x6 frame, one sample per clock.
        brightCnt = 0; vSyncCnt = 0; tickCnt = 0; lineCnt = 0; frameCnt = 0; hSyncErr = 0;
        firstH = -1; firstV = -1; firstX = -1; firstY = -1;
        lastH = -1; lastV = -1; lastX = -1; lastY = -1; maxX = -1;
        for (int i = 0; i < 96; i++) begin
            if (brightB) begin
                brightCnt++;
                if (firstH < 0) begin
                    firstH = hCountB; firstV = vCountB; firstX = xB; firstY = yB;
                end
                lastH = hCountB; lastV = vCountB; lastX = xB; lastY = yB;
                if (int'(xB) > maxX) maxX = xB;
            end
            if (vSyncB) vSyncCnt++;
            if (tickB) tickCnt++;
            if (lineB) lineCnt++;
            if (frameB) frameCnt++;
            if (hSyncB != (hCountB < 8)) hSyncErr++;
            stepClock();
        end
        checkOutput("B bright count", brightCnt, 12);
        checkOutput("B vSync active clks", vSyncCnt, 16);
        checkOutput("B pix_tick count", tickCnt, 96);
        checkOutput("B line_start count", lineCnt, 6);
        checkOutput("B frame_start count", frameCnt, 1);
        checkOutput("B hSync decode errors", hSyncErr, 0);
        checkOutput("B first bright h", firstH, 10);
        checkOutput("B first bright v", firstV, 2);
        checkOutput("B first bright x", firstX, 0);
        checkOutput("B first bright y", firstY, 0);
        checkOutput("B last bright h", lastH, 13);
        checkOutput("B last bright v", lastV, 4);
        checkOutput("B last bright x", lastX, 3);
        checkOutput("B last bright y", lastY, 2);
        checkOutput("B max x", maxX, 3);
        checkOutput("B next frame_start", frameB, 1);
        checkOutput("B next line_start", lineB, 1);
        checkOutput("B next hCount", hCountB, 0);
        checkOutput("B next vCount", vCountB, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised successor to the fixed 640x480 VGA display controller. It generates horizontal and vertical sync, the display-enable (`bright`) signal, raw beam counters and active-area pixel coordinates, with every timing field, sync polarity and the pixel-rate divider set by parameters. It runs entirely in the `clk` domain, using a clock enable instead of derived clocks. It sits between the board clock and the pixel-generation and colour logic, driving the VGA connector pins.

## Interface
- `DIV`, 4: system clocks per pixel; must be ≥1 (4 gives 25 MHz from 100 MHz).
- `CW`, 10: counter and coordinate width; H_TOTAL and V_TOTAL must be ≤ 2^CW.
- `H_SYNC`, `H_BACK`, `H_ACTIVE`, `H_FRONT`: 96, 48, 640, 16 (pixels).
- `V_SYNC`, `V_BACK`, `V_ACTIVE`, `V_FRONT`: 2, 33, 480, 10 (lines).
- `H_POL`, `V_POL`: 0, 0. Sync active level; 0 means active-low.
- `clk` in, 1 bit: system clock.
- `reset` in, 1 bit: synchronous, active-high.
- `enable` in, 1 bit: when low, the divider and counters hold.
- `hSync`, `vSync` out, 1 bit each: sync outputs, polarity per parameter.
- `bright` out, 1 bit: beam is inside the active area.
- `hCount`, `vCount` out, CW bits each: raw beam position.
- `x`, `y` out, CW bits each: active-area coordinates; 0 outside the active area.
- `pix_tick` out, 1 bit: one-clk pulse in each cycle where new counter values first appear.
- `line_start`, `frame_start` out, 1 bit each: one-clk pulses when hCount becomes 0, and when (hCount, vCount) becomes (0, 0).

## Operation
- H_TOTAL = sum of the four H fields; V_TOTAL = sum of the four V fields. Each line and each frame runs in the order sync, back porch, active, front porch, starting at count 0.
- Divider: `div_cnt` counts 0..DIV-1 and wraps, advancing only while `enable` is high. The internal pixel enable `pe` = `enable` && (`div_cnt` == DIV-1). With DIV=1, `pe` = `enable`.
- On each `pe`:
  - hCount increments.
  - At H_TOTAL-1, hCount wraps to 0 and vCount increments.
  - At vCount = V_TOTAL-1 with hCount = H_TOTAL-1, both counters wrap to 0.
- Decodes are computed from the next-state counts and registered, so they stay consistent with the hCount/vCount values presented in the same cycle:
  - `hSync` is at the active level iff hCount < H_SYNC.
  - `vSync` is at the active level iff vCount < V_SYNC.
  - `bright` = (H_SYNC+H_BACK ≤ hCount < H_SYNC+H_BACK+H_ACTIVE) && (V_SYNC+V_BACK ≤ vCount < V_SYNC+V_BACK+V_ACTIVE). Both bounds are exact: 640x480 gives exactly 640 active pixels per line and 480 active lines per frame.
  - `x` = hCount - (H_SYNC+H_BACK) and `y` = vCount - (V_SYNC+V_BACK) when `bright`; otherwise both are 0.
- `pix_tick`, `line_start` and `frame_start` are registered pulses, high for exactly one clk each.
- When `enable` is low, all counters and level outputs hold and all pulse outputs are 0.

## Timing
- Reset values:
  - `hCount`, `vCount`, `x`, `y`, `div_cnt` = 0.
  - `bright` = 0; `pix_tick` = 0; `line_start` = 0; `frame_start` = 0.
  - `hSync` = H_POL and `vSync` = V_POL, i.e. the active level, because count 0 lies in the sync region.
- Reset asserted mid-frame forces the reset values on the next clk edge and takes priority over `enable`.
- After reset deasserts with `enable` high, hCount first becomes 1 on the DIV-th rising edge. Every later change comes DIV edges after the previous one.
- Output latency is 0 cycles relative to the counters: all outputs change on the same edge as hCount/vCount.
- Simultaneous line and frame wrap: `line_start` and `frame_start` are both high in the same clk.

## Structure
- Shared package `vga_timing_pkg`:
  - default 640x480@60 timing constants;
  - derived H_TOTAL, V_TOTAL and active-start localparams;
  - a polarity encoding constant.
- One natural sub-module, `vga_axis_timer`, instantiated once for H and once for V. It holds a wrap counter with an advance input and a carry output, plus the sync, active and coordinate decodes.
- The top level holds the divider, output registers and pulse generation, and elaboration-time checks on DIV ≥ 1 and the totals fitting in CW bits.

## Test plan
- Reset release, defaults: `pix_tick` occurs every 4 clks. hCount = 1 on the 4th edge; hSync goes high at hCount = 96; `bright` first rises at (144, 35) with x = 0, y = 0.
- Full frame, defaults: 800x525 pixel ticks per `frame_start`. `bright` high for exactly 307200 ticks; last active pixel is (783, 514) with x = 639, y = 479. `vSync` is low for exactly 2 lines.
- Wrap boundary: at (799, 524) the next tick gives (0, 0) with `line_start` = `frame_start` = 1 in the same clk. At (799, 10) the next tick gives (0, 11) with only `line_start` = 1.
- `enable` dropped for 37 clks mid-line: all counters and levels hold, no pulses, and the tick phase resumes exactly where it stopped.
- Reset asserted at (500, 200): the next edge gives 0, 0, `hSync` = `vSync` = 0, `bright` = 0.
- DIV=1, H_POL = V_POL = 1, with a small 8/2/4/2 H and 1/1/3/1 V timing: a tick every clk, H_TOTAL = 16, V_TOTAL = 6, sync outputs active-high, x runs 0..3.
